// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract with one carry slice per stage,
// valid/ready flow control, optional signed saturation and NZCV flags.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_sub,
    input  logic             is_sat,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int STAGES = (WIDTH / CHUNK < 1) ? 1 : WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage registers. Operand b is stored already conditioned
    // (inverted for subtract), so later stages never need is_sub.
    logic             vld_q [STAGES];
    logic             sat_q [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];

    // Values presented to each stage and what it computes from them.
    logic             src_vld [STAGES];
    logic             src_sat [STAGES];
    logic             src_c   [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_s   [STAGES];
    logic [CHUNK-1:0] slc_s   [STAGES];
    logic             slc_c   [STAGES];
    logic [WIDTH-1:0] nxt_s   [STAGES];

    logic             stall;
    logic             msb_cin;
    logic             raw_v;
    logic             sat_hit;
    logic [WIDTH-1:0] res;

    // A held result blocks the whole pipe, bubbles included.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Per-stage slice adder: stage k resolves bits of slice k only.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_vld[k] = in_valid;
                src_sat[k] = is_sat;
                src_c[k]   = is_sub;
                src_a[k]   = a;
                src_b[k]   = is_sub ? ~b : b;
                src_s[k]   = '0;
            end else begin
                src_vld[k] = vld_q[k-1];
                src_sat[k] = sat_q[k-1];
                src_c[k]   = cy_q[k-1];
                src_a[k]   = opa_q[k-1];
                src_b[k]   = opb_q[k-1];
                src_s[k]   = sum_q[k-1];
            end
            {slc_c[k], slc_s[k]} =
                {1'b0, src_a[k][k*CHUNK +: CHUNK]}
              + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = slc_s[k];
        end
    end

    // Final stage: recover carry into the MSB, detect overflow, clamp.
    always_comb begin
        msb_cin = slc_s[LAST][CHUNK-1]
                ^ src_a[LAST][WIDTH-1]
                ^ src_b[LAST][WIDTH-1];
        raw_v   = msb_cin ^ slc_c[LAST];
        sat_hit = src_sat[LAST] && raw_v;
        res     = nxt_s[LAST];
        if (sat_hit) begin
            res = src_a[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Pipeline advance; everything freezes while the output is stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                sat_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
            end
            out_valid <= 1'b0;
            out       <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= src_vld[k];
                sat_q[k] <= src_sat[k];
                cy_q[k]  <= slc_c[k];
                opa_q[k] <= src_a[k];
                opb_q[k] <= src_b[k];
                sum_q[k] <= nxt_s[k];
            end
            out_valid <= src_vld[LAST];
            if (src_vld[LAST]) begin
                out    <= res;
                flag_n <= res[WIDTH-1];
                flag_z <= (res == '0);
                flag_c <= slc_c[LAST];
                flag_v <= raw_v;
            end
        end
    end

endmodule
